nrzi_rx_unstuffer: RTL and testbench

- Next-generation USB receive-front-end bit decoder.
- NRZI-decodes the sampled dp/dm line pair, removes stuffed bits after a parametrised run of ones, flags stuffing violations, and detects SE0-based end-of-packet.
- Sits between the bit-sample strobe generator and the receive shift register; downstream shifts only when d_valid is high.

---
 rtl/nrzi_rx_unstuffer.sv | 206 ++++++++++++++++++++
 tb/tb_nrzi_rx_unstuffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nrzi_rx_unstuffer.sv
// nrzi_rx_unstuffer: USB receive front end bit decoder.
// NRZI-decodes the sampled dp/dm pair, removes stuffed zeros after STUFF_LEN
// consecutive ones, flags stuffing/framing violations and detects SE0-based EOP.
// Optional feature macro: NRZI_SYNC_DETECT_EN adds a SYNC state that matches
// the 00000001 sync pattern before payload bits are passed, plus a sync_found pulse.
module nrzi_rx_unstuffer #(
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter bit IDLE_DP      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic dp_in,
    input  logic dm_in,
    output logic d_orig,
    output logic d_valid,
    output logic d_edge,
    output logic stuff_drop,
    output logic stuff_err,
    output logic eop,
`ifdef NRZI_SYNC_DETECT_EN
    output logic sync_found,
`endif
    output logic rx_active
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int SW = $clog2(EOP_SE0_BITS + 1);
    localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
    localparam logic [SW-1:0] SE0_MAX  = SW'(EOP_SE0_BITS);
    localparam logic          IDLE_LVL = IDLE_DP;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_ERROR  = 2'd2;
`ifdef NRZI_SYNC_DETECT_EN
    localparam logic [1:0] S_SYNC   = 2'd3;
`endif

    function automatic logic [OW-1:0] sat_ones(input logic [OW-1:0] v);
        return (v >= ONES_MAX) ? ONES_MAX : v + OW'(1);
    endfunction

    function automatic logic [SW-1:0] sat_se0(input logic [SW-1:0] v);
        return (v >= SE0_MAX) ? SE0_MAX : v + SW'(1);
    endfunction

    logic [1:0]    state, state_p0;
    logic          prev_dp, prev_dp_p0;
    logic [OW-1:0] ones_cnt, ones_p0;
    logic [SW-1:0] se0_cnt, se0_p0;
    logic          d_orig_p0, vld_p0, edge_p0, drop_p0, err_p0, eop_p0, act_p0;
    logic          line_se0, line_edge, line_bit;
`ifdef NRZI_SYNC_DETECT_EN
    logic [2:0]    sync_cnt, sync_cnt_p0;
    logic          sync_p0;
`endif

    // Both-low and both-high line states carry no data and are handled as SE0.
    assign line_se0  = (dp_in == dm_in);
    assign line_edge = dp_in ^ prev_dp;
    assign line_bit  = ~line_edge;

    // Decode decision for the current sample; EOP/framing check wins over data decode.
    always_comb begin
        state_p0   = state;
        prev_dp_p0 = prev_dp;
        ones_p0    = ones_cnt;
        se0_p0     = se0_cnt;
        d_orig_p0  = d_orig;
        vld_p0     = 1'b0;
        edge_p0    = 1'b0;
        drop_p0    = 1'b0;
        err_p0     = 1'b0;
        eop_p0     = 1'b0;
`ifdef NRZI_SYNC_DETECT_EN
        sync_cnt_p0 = sync_cnt;
        sync_p0     = 1'b0;
`endif
        if (en) begin
            if (line_se0) begin
                ones_p0 = '0;
                if (state == S_ACTIVE || state == S_ERROR) begin
                    se0_p0 = sat_se0(se0_cnt);
                end
`ifdef NRZI_SYNC_DETECT_EN
                if (state == S_SYNC) begin
                    state_p0 = S_IDLE;
                end
`endif
            end else begin
                edge_p0    = line_edge;
                prev_dp_p0 = dp_in;
                case (state)
                    S_IDLE: begin
                        ones_p0 = '0;
                        if (line_edge) begin
`ifdef NRZI_SYNC_DETECT_EN
                            // The first K is the first sync zero.
                            state_p0    = S_SYNC;
                            sync_cnt_p0 = 3'd1;
`else
                            state_p0  = S_ACTIVE;
                            d_orig_p0 = 1'b0;
                            vld_p0    = 1'b1;
`endif
                        end
                    end
                    S_ACTIVE, S_ERROR: begin
                        if (se0_cnt != '0) begin
                            // First non-SE0 sample after SE0: never data.
                            se0_p0  = '0;
                            ones_p0 = '0;
                            if (se0_cnt >= SE0_MAX && dp_in == IDLE_LVL) begin
                                eop_p0     = 1'b1;
                                state_p0   = S_IDLE;
                                prev_dp_p0 = IDLE_LVL;
                            end else begin
                                err_p0   = 1'b1;
                                state_p0 = S_ERROR;
                            end
                        end else if (state == S_ACTIVE) begin
                            if (ones_cnt == ONES_MAX) begin
                                ones_p0 = '0;
                                if (line_bit) begin
                                    err_p0   = 1'b1;
                                    state_p0 = S_ERROR;
                                end else begin
                                    drop_p0 = 1'b1;
                                end
                            end else begin
                                d_orig_p0 = line_bit;
                                vld_p0    = 1'b1;
                                ones_p0   = line_bit ? sat_ones(ones_cnt) : '0;
                            end
                        end else begin
                            ones_p0 = '0;
                        end
                    end
`ifdef NRZI_SYNC_DETECT_EN
                    S_SYNC: begin
                        if (line_bit == (sync_cnt == 3'd7)) begin
                            if (sync_cnt == 3'd7) begin
                                sync_p0  = 1'b1;
                                state_p0 = S_ACTIVE;
                                ones_p0  = OW'(1);
                            end else begin
                                sync_cnt_p0 = sync_cnt + 3'd1;
                                ones_p0     = '0;
                            end
                        end else begin
                            state_p0 = S_IDLE;
                            ones_p0  = '0;
                        end
                    end
`endif
                    default: begin
                        state_p0 = S_IDLE;
                        ones_p0  = '0;
                        se0_p0   = '0;
                    end
                endcase
            end
        end
        act_p0 = (state_p0 == S_ACTIVE) || (state_p0 == S_ERROR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            prev_dp    <= IDLE_LVL;
            ones_cnt   <= '0;
            se0_cnt    <= '0;
            d_orig     <= 1'b0;
            d_valid    <= 1'b0;
            d_edge     <= 1'b0;
            stuff_drop <= 1'b0;
            stuff_err  <= 1'b0;
            eop        <= 1'b0;
            rx_active  <= 1'b0;
`ifdef NRZI_SYNC_DETECT_EN
            sync_cnt   <= 3'd0;
            sync_found <= 1'b0;
`endif
        end else begin
            state      <= state_p0;
            prev_dp    <= prev_dp_p0;
            ones_cnt   <= ones_p0;
            se0_cnt    <= se0_p0;
            d_orig     <= d_orig_p0;
            d_valid    <= vld_p0;
            d_edge     <= edge_p0;
            stuff_drop <= drop_p0;
            stuff_err  <= err_p0;
            eop        <= eop_p0;
            rx_active  <= act_p0;
`ifdef NRZI_SYNC_DETECT_EN
            sync_cnt   <= sync_cnt_p0;
            sync_found <= sync_p0;
`endif
        end
    end

endmodule

// File: tb/tb_nrzi_rx_unstuffer.sv
// Directed testbench for nrzi_rx_unstuffer (default build, sync detect disabled).
module tb_nrzi_rx_unstuffer;

    logic clk;
    logic rst;
    logic en;
    logic dp_in;
    logic dm_in;
    logic d_orig, d_valid, d_edge, stuff_drop, stuff_err, eop, rx_active;
    logic [6:0] obs;

    int checks = 0;
    int errors = 0;

    // Output vector bit order: orig, valid, edge, drop, err, eop, active.
    localparam logic [6:0] M_ALL    = 7'b111_1111;
    localparam logic [6:0] M_NOEDGE = 7'b110_1111;

    nrzi_rx_unstuffer #(
        .STUFF_LEN(6),
        .EOP_SE0_BITS(2),
        .IDLE_DP(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .dp_in(dp_in),
        .dm_in(dm_in),
        .d_orig(d_orig),
        .d_valid(d_valid),
        .d_edge(d_edge),
        .stuff_drop(stuff_drop),
        .stuff_err(stuff_err),
        .eop(eop),
        .rx_active(rx_active)
    );

    assign obs = {d_orig, d_valid, d_edge, stuff_drop, stuff_err, eop, rx_active};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] exp, input logic [6:0] mask);
        checks++;
        assert ((obs & mask) === (exp & mask)) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs & mask, exp & mask);
        end
    endtask

    task automatic step(input logic e, input logic dp, input logic dm);
        en    = e;
        dp_in = dp;
        dm_in = dm;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input logic dp);
        step(1'b1, dp, ~dp);
    endtask

    task automatic se0();
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        dp_in = 1'b1;
        dm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 7'b000_0000, M_ALL);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk("after_release", 7'b000_0000, M_ALL);

        // Idle: SE0 and J are ignored
        se0();
        chk("idle_se0", 7'b000_0000, M_ALL);
        line(1'b1);
        chk("idle_j", 7'b000_0000, M_ALL);

        // Basic decode: dp 0,1,1,0 from idle J
        line(1'b0);
        chk("basic_0", 7'b011_0001, M_ALL);
        line(1'b1);
        chk("basic_1", 7'b011_0001, M_ALL);
        line(1'b1);
        chk("basic_2", 7'b110_0001, M_ALL);
        line(1'b0);
        chk("basic_3", 7'b011_0001, M_ALL);

        // EOP: SE0, SE0, J
        se0();
        chk("eop_se0a", 7'b000_0001, M_ALL);
        se0();
        chk("eop_se0b", 7'b000_0001, M_ALL);
        line(1'b1);
        chk("eop_j", 7'b001_0010, M_NOEDGE);
        line(1'b1);
        chk("post_eop_idle", 7'b000_0000, M_ALL);

        // Stuff removal: 0, six 1s, stuffed 0, then normal bits
        line(1'b0);
        chk("stuff_first", 7'b011_0001, M_ALL);
        for (int i = 0; i < 6; i++) begin
            line(1'b0);
            chk($sformatf("stuff_one%0d", i), 7'b110_0001, M_ALL);
        end
        line(1'b1);
        chk("stuff_drop", 7'b101_1001, M_ALL);
        line(1'b1);
        chk("after_drop_1", 7'b110_0001, M_ALL);
        line(1'b0);
        chk("after_drop_0", 7'b011_0001, M_ALL);
        line(1'b0);
        chk("pre_gate_1", 7'b110_0001, M_ALL);

        // en gating: line toggles while en=0, last sampled level is 0
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, (i % 2 == 0) ? 1'b0 : 1'b1);
            chk($sformatf("gate%0d", i), 7'b100_0001, M_ALL);
        end
        line(1'b0);
        chk("gate_resume", 7'b110_0001, M_ALL);

        // Stuff error: 0 then seven 1s
        line(1'b1);
        chk("serr_zero", 7'b011_0001, M_ALL);
        for (int i = 0; i < 6; i++) begin
            line(1'b1);
            chk($sformatf("serr_one%0d", i), 7'b110_0001, M_ALL);
        end
        line(1'b1);
        chk("stuff_err", 7'b100_0101, M_ALL);
        line(1'b0);
        chk("error_discard", 7'b101_0001, M_ALL);
        se0();
        chk("err_se0a", 7'b100_0001, M_ALL);
        se0();
        chk("err_se0b", 7'b100_0001, M_ALL);
        line(1'b1);
        chk("err_eop", 7'b101_0010, M_NOEDGE);

        // Single SE0 then J: framing error, no eop
        line(1'b0);
        chk("short_start", 7'b011_0001, M_ALL);
        se0();
        chk("short_se0", 7'b000_0001, M_ALL);
        line(1'b1);
        chk("short_j_err", 7'b001_0101, M_NOEDGE);
        se0();
        chk("short_rec_se0a", 7'b000_0001, M_ALL);
        se0();
        chk("short_rec_se0b", 7'b000_0001, M_ALL);
        line(1'b1);
        chk("short_rec_eop", 7'b000_0010, M_NOEDGE);

        // SE0, SE0 then K: framing error
        line(1'b0);
        chk("kret_start", 7'b011_0001, M_ALL);
        se0();
        chk("kret_se0a", 7'b000_0001, M_ALL);
        se0();
        chk("kret_se0b", 7'b000_0001, M_ALL);
        line(1'b0);
        chk("kret_err", 7'b000_0101, M_NOEDGE);
        se0();
        chk("kret_rec_se0a", 7'b000_0001, M_ALL);
        se0();
        chk("kret_rec_se0b", 7'b000_0001, M_ALL);
        line(1'b1);
        chk("kret_rec_eop", 7'b000_0010, M_NOEDGE);

        // Reset mid-packet with ones_cnt=4
        line(1'b0);
        chk("rst_pkt_start", 7'b011_0001, M_ALL);
        for (int i = 0; i < 4; i++) begin
            line(1'b0);
            chk($sformatf("rst_pkt_one%0d", i), 7'b110_0001, M_ALL);
        end
        en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", 7'b000_0000, M_ALL);
        @(posedge clk);
        #1;
        rst = 1'b0;
        line(1'b1);
        chk("rst_idle_j", 7'b000_0000, M_ALL);
        line(1'b0);
        chk("rst_new_start", 7'b011_0001, M_ALL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
